// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer counter consumer.
// Gray nibble decode reference and capture FSM state type.
package timer_pkg;

    localparam int NIB_W = 4;

    typedef enum logic {CAP_IDLE, CAP_HOLD} cap_state_e;

    function automatic logic [NIB_W-1:0] gray4_to_bin(input logic [NIB_W-1:0] g);
        logic [NIB_W-1:0] b;
        b[NIB_W-1] = g[NIB_W-1];
        for (int i = NIB_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray4_decode.sv
// Combinational 4-bit Gray to binary nibble decoder.
module gray4_decode
    import timer_pkg::*;
(
    input  logic [NIB_W-1:0] gray,
    output logic [NIB_W-1:0] bin
);

    assign bin[3] = gray[3];
    assign bin[2] = bin[3] ^ gray[2];
    assign bin[1] = bin[2] ^ gray[1];
    assign bin[0] = bin[1] ^ gray[0];

endmodule

// File: rtl/gray_capture_decoder.sv
// Gray count consumer: decode, epoch counter, compare pulse and
// snapshot capture handed out over a valid/ready handshake.
module gray_capture_decoder
    import timer_pkg::*;
#(
    parameter int W     = 8,
    parameter int OVF_W = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [W-1:0]       gray_in,
    input  logic               tc_in,
    input  logic               cmp_en,
    input  logic [W-1:0]       cmp_val,
    input  logic               cap_req,
    input  logic               rd_ready,
    output logic [W-1:0]       bin_out,
    output logic [OVF_W-1:0]   ovf_cnt,
    output logic               cmp_match,
    output logic               cap_valid,
    output logic [OVF_W+W-1:0] cap_data,
    output logic               cap_overrun
);

    logic [W-1:0] bin_dec;
    logic [W-1:0] bin_prev;
    logic         tc_q;
    cap_state_e   state;

    for (genvar i = 0; i < W / NIB_W; i++) begin : g_nib
        gray4_decode u_dec (
            .gray (gray_in[i*NIB_W +: NIB_W]),
            .bin  (bin_dec[i*NIB_W +: NIB_W])
        );
    end

    assign cap_valid = (state == CAP_HOLD);

    always_ff @(posedge clk) begin
        if (clr) begin
            bin_out   <= '0;
            bin_prev  <= '0;
            tc_q      <= 1'b0;
            ovf_cnt   <= '0;
            cmp_match <= 1'b0;
        end else begin
            bin_out   <= bin_dec;
            bin_prev  <= bin_out;
            tc_q      <= tc_in;
            if (tc_in && !tc_q)
                ovf_cnt <= ovf_cnt + 1'b1;
            // Only a fresh arrival at the compare value fires
            cmp_match <= cmp_en && (bin_out == cmp_val) && (bin_out != bin_prev);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= CAP_IDLE;
            cap_data    <= '0;
            cap_overrun <= 1'b0;
        end else begin
            unique case (state)
                CAP_IDLE: begin
                    if (cap_req) begin
                        cap_data <= {ovf_cnt, bin_out};
                        state    <= CAP_HOLD;
                    end
                end
                CAP_HOLD: begin
                    if (rd_ready && cap_req) begin
                        cap_data <= {ovf_cnt, bin_out};
                    end else if (rd_ready) begin
                        state <= CAP_IDLE;
                    end else if (cap_req) begin
                        cap_overrun <= 1'b1;
                    end
                end
                default: state <= CAP_IDLE;
            endcase
        end
    end

endmodule

// File: doc/gray_capture_decoder.md
Name: gray_capture_decoder

Overview:
- Consumer at the far end of the timer counter interface.
- Takes the 8-bit count bus, made of two independent 4-bit Gray nibbles (low nibble = bits [3:0], high nibble = bits [7:4]), plus the terminal-count pulse.
- Decodes the count to binary, extends it with an overflow (epoch) counter, raises a compare-match pulse and holds snapshots on request.
- Snapshots are handed to a reader over a valid/ready handshake.

Parameters:
- W, 8, count bus width; must be a multiple of 4, decoded nibble-wise.
- OVF_W, 8, width of the overflow epoch counter.

Ports:
- clk  input  1  clock.
- clr  input  1  synchronous active-high reset.
- gray_in  input  W  count bus; each 4-bit nibble is Gray coded.
- tc_in  input  1  terminal count from the counter (count_triger).
- cmp_en  input  1  enables compare-match generation.
- cmp_val  input  W  binary compare value.
- cap_req  input  1  single-cycle capture request.
- rd_ready  input  1  reader accepts the snapshot.
- bin_out  output  W  registered binary count.
- ovf_cnt  output  OVF_W  tc rising-edge count.
- cmp_match  output  1  single-cycle match pulse.
- cap_valid  output  1  snapshot available.
- cap_data  output  OVF_W+W  snapshot {ovf_cnt, bin_out}.
- cap_overrun  output  1  sticky lost-capture flag.

Behaviour:
- Reset: the only reset is clr, synchronous and active-high on clk. Effects:
  - All outputs go to 0; tc edge register 0; state CAP_IDLE.
  - clr wins over every other input in the same cycle, including a snapshot mid-handshake, which is dropped.
- Decode, per nibble:
  - b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0.
  - Nibbles are decoded independently and concatenated.
  - bin_out is registered: gray_in sampled at edge n appears on bin_out after edge n (1-cycle latency).
- Overflow counter:
  - tc_q <= tc_in each cycle.
  - ovf_cnt increments by 1 when tc_in & !tc_q.
  - A level held high counts once.
  - Wraps from 2^OVF_W-1 to 0 silently.
- Compare:
  - cmp_match pulses 1 cycle when cmp_en=1, bin_out==cmp_val, and bin_out changed on the previous edge. bin_out is compared to its previous value, held in a bin_prev register.
  - A stalled count equal to cmp_val does not re-fire.
  - Match is registered: asserted the cycle after bin_out takes the matching value.
- Capture FSM, states CAP_IDLE and CAP_HOLD:
  - CAP_IDLE:
    - cap_req=1: cap_data <= {ovf_cnt, bin_out} as seen that cycle, then go to CAP_HOLD.
    - cap_valid=1 from the next cycle.
  - CAP_HOLD:
    - cap_valid=1 and cap_data stable.
    - rd_ready=1 and no cap_req: transfer completes, go to CAP_IDLE, cap_valid=0 next cycle.
    - rd_ready=1 and cap_req in the same cycle: new snapshot loaded, stay in CAP_HOLD; cap_valid stays 1 with no bubble.
    - cap_req with rd_ready=0: request dropped, data unchanged, cap_overrun <= 1.
    - cap_overrun clears only on clr.
- Simultaneous tc edge and cap_req: the snapshot takes the pre-increment ovf_cnt.
- Capture is taken from the registered bin_out, so it reflects gray_in from one cycle before cap_req.

Decomposition:
- timer_pkg holds:
  - typedef enum logic cap_state_e {CAP_IDLE, CAP_HOLD};
  - localparam NIB_W=4;
  - function gray4_to_bin for shared use by the counter bench model.
- One sub-module, gray4_decode: combinational nibble decoder, instanced W/4 times through a generate loop.
- The top holds all flops and the FSM.

Test Plan:
- Decode sweep: drive gray_in=8'h8C, one edge later bin_out=8'hF8; drive 8'h00 then bin_out=8'h00; drive all 256 nibble-Gray codes and compare bin_out against timer_pkg::gray4_to_bin per nibble.
- Overflow: hold tc_in=1 for 5 cycles, then ovf_cnt=1; give 256 separate pulses from reset, then ovf_cnt=0 (wrapped); check simultaneous cap_req captures the pre-increment value.
- Compare: cmp_en=1, cmp_val=8'h2A; step bin_out 0x29, 0x2A, hold 0x2A 3 cycles, then exactly one cmp_match pulse, 1 cycle after 0x2A appears; repeat with cmp_en=0 and see no pulse.
- Handshake: cap_req with ovf_cnt=3, bin_out=0x10, so cap_data=16'h0310 and cap_valid=1 next cycle; hold rd_ready=0 for 4 cycles (data stable), then rd_ready=1 and cap_valid=0 next cycle.
- Overrun and back-to-back:
  - cap_req while CAP_HOLD and rd_ready=0: cap_overrun=1, cap_data unchanged.
  - cap_req together with rd_ready=1: new data loaded, cap_valid stays 1.
- Reset mid-operation: assert clr in CAP_HOLD with ovf_cnt=7; next cycle all outputs 0 and cap_overrun cleared; clr with cap_req in the same cycle gives no capture.
